// File: rtl/altair_mtimer_if.sv
// altair_mtimer_if -- Wishbone classic bus bundle for the Altair IO port.
//
// Signals (the core names these io__<signal>):
//   adr    6  byte address; only [4:2] are decoded by the timer
//   dat_w  32 write data
//   sel    4  byte lane enables for writes
//   we     1  write enable
//   cyc    1  bus cycle valid
//   stb    1  strobe
//   dat_r  32 read data, valid only while ack is high
//   ack    1  single-cycle acknowledge
//   err    1  single-cycle error (unmapped address)
//
// Modports: master (the core / testbench), slave (the timer).
interface altair_mtimer_if;
  logic [5:0]  adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  modport master (
    output adr, dat_w, sel, we, cyc, stb,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb,
    output dat_r, ack, err
  );
endinterface

// File: rtl/altair_mtimer.sv
// altair_mtimer -- machine-mode timer and software-interrupt controller.
//
// A Wishbone classic slave holding a 64-bit free-running mtime counter,
// a 64-bit mtimecmp compare register and the msip bit. It drives the core's
// timer_interrupt (registered mtime >= mtimecmp) and software_interrupt (msip).
//
// Ports:
//   clk                 sole clock
//   rst                 asynchronous active-low reset
//   io                  altair_mtimer_if.slave bus (adr/dat_w/sel/we/cyc/stb in,
//                       dat_r/ack/err out)
//   timer_interrupt     registered unsigned compare mtime >= mtimecmp
//   software_interrupt  the msip register
//
// Register map (byte offsets, adr[4:2] decoded):
//   0x00 MTIME_LO  0x04 MTIME_HI  0x08 MTIMECMP_LO  0x0C MTIMECMP_HI
//   0x10 MSIP (bit 0)  0x14 PRESCALE (only with the macro)  others: err
//
// Configuration macro: ALTAIR_MTIMER_PRESCALE_EN
//   defined   -> PRESCALE register + counter, 0x14 mapped read/write
//   undefined -> mtime ticks every clock, 0x14 responds with err
module altair_mtimer #(
  parameter int PRESCALE_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  altair_mtimer_if.slave io,
  output logic           timer_interrupt,
  output logic           software_interrupt
);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  localparam logic [2:0] A_MTIME_LO    = 3'd0;
  localparam logic [2:0] A_MTIME_HI    = 3'd1;
  localparam logic [2:0] A_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] A_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] A_MSIP        = 3'd4;
  localparam logic [2:0] A_PRESCALE    = 3'd5;

  state_t      r_state, w_state_nx;
  logic [63:0] r_mtime, r_mtimecmp;
  logic [63:0] w_mtime_inc, w_mtime_nx, w_mtimecmp_nx;
  logic        r_msip, r_tint, r_ack, r_err;
  logic [31:0] r_dat_r, w_rdata;
  logic [2:0]  w_idx;
  logic        w_acc, w_mapped, w_wr, w_tick;
  logic        w_pre_map;
  logic [31:0] w_pre_rd;
  logic        w_unused;

  // Byte-lane merge: lanes with be set take wd, the rest keep old.
  function automatic logic [31:0] f_merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0]  be);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) res[8*b +: 8] = wd[8*b +: 8];
    return res;
  endfunction

  // adr[5] is not decoded, so the upper 32 bytes alias the lower 32;
  // adr[1:0] select nothing since all registers are whole words.
  assign w_unused = ^{io.adr[5], io.adr[1:0]};
  assign w_idx    = io.adr[4:2];

  // An access is captured only in IDLE; a strobe seen in RESP is dropped,
  // which limits throughput to one access every two cycles.
  assign w_acc    = (r_state == S_IDLE) && io.cyc && io.stb;
  assign w_mapped = (w_idx <= A_MSIP) || (w_pre_map && (w_idx == A_PRESCALE));
  assign w_wr     = w_acc && io.we && w_mapped;

`ifdef ALTAIR_MTIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] r_pre, r_pcnt;
  logic [31:0]           w_pre32, w_pre_wr;
  logic                  w_pre_wr_en;

  assign w_pre32     = 32'(r_pre);
  assign w_pre_wr    = f_merge(w_pre32, io.dat_w, io.sel);
  // A sel==0 write is a no-op, so it must not restart the counter either.
  assign w_pre_wr_en = w_wr && (w_idx == A_PRESCALE) && (io.sel != 4'd0);
  // Counter runs 0..prescale; prescale=0 means a tick every cycle.
  assign w_tick      = (r_pcnt == r_pre);
  assign w_pre_map   = 1'b1;
  assign w_pre_rd    = w_pre32;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre  <= '0;
      r_pcnt <= '0;
    end else begin
      if (w_pre_wr_en) begin
        r_pre  <= PRESCALE_W'(w_pre_wr);
        r_pcnt <= '0;
      end else if (w_tick) begin
        r_pcnt <= '0;
      end else begin
        r_pcnt <= r_pcnt + PRESCALE_W'(1);
      end
    end
  end
`else
  localparam int unused_prescale_w = PRESCALE_W;
  assign w_tick    = 1'b1;
  assign w_pre_map = 1'b0;
  assign w_pre_rd  = '0;
`endif

  // Bus FSM: IDLE -> RESP on a strobe, RESP -> IDLE always.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (io.cyc && io.stb) w_state_nx = S_RESP;
      S_RESP:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Read mux works on pre-edge register values (no hi/lo snapshot).
  always_comb begin
    w_rdata = '0;
    case (w_idx)
      A_MTIME_LO:    w_rdata = r_mtime[31:0];
      A_MTIME_HI:    w_rdata = r_mtime[63:32];
      A_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
      A_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
      A_MSIP:        w_rdata = {31'd0, r_msip};
      A_PRESCALE:    w_rdata = w_pre_rd;
      default:       w_rdata = '0;
    endcase
  end

  // mtime write merges onto the already-incremented value: written bytes
  // win, untouched bytes and the other half keep the tick (with carry).
  always_comb begin
    w_mtime_inc   = r_mtime + 64'(w_tick);
    w_mtime_nx    = w_mtime_inc;
    w_mtimecmp_nx = r_mtimecmp;
    if (w_wr) begin
      case (w_idx)
        A_MTIME_LO:    w_mtime_nx[31:0]     = f_merge(w_mtime_inc[31:0], io.dat_w, io.sel);
        A_MTIME_HI:    w_mtime_nx[63:32]    = f_merge(w_mtime_inc[63:32], io.dat_w, io.sel);
        A_MTIMECMP_LO: w_mtimecmp_nx[31:0]  = f_merge(r_mtimecmp[31:0], io.dat_w, io.sel);
        A_MTIMECMP_HI: w_mtimecmp_nx[63:32] = f_merge(r_mtimecmp[63:32], io.dat_w, io.sel);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
      r_tint     <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_dat_r    <= '0;
    end else begin
      r_mtime    <= w_mtime_nx;
      r_mtimecmp <= w_mtimecmp_nx;
      if (w_wr && (w_idx == A_MSIP) && io.sel[0]) r_msip <= io.dat_w[0];
      // Compare of current register values, visible one cycle later.
      r_tint     <= (r_mtime >= r_mtimecmp);
      r_ack      <= w_acc && w_mapped;
      r_err      <= w_acc && !w_mapped;
      // dat_r is zero outside a read response.
      r_dat_r    <= (w_acc && w_mapped && !io.we) ? w_rdata : '0;
    end
  end

  assign io.dat_r           = r_dat_r;
  assign io.ack             = r_ack;
  assign io.err             = r_err;
  assign timer_interrupt    = r_tint;
  assign software_interrupt = r_msip;

endmodule
